// File: rtl/scroll_lanes.sv
// scroll_lanes: NUM_LANES horizontal scroll offsets that advance together on
// a shared prescaler tick. The tick period shrinks as the score rises. Each
// lane moves by its own step and direction and wraps modulo SCREEN_WIDTH.
module scroll_lanes #(
  parameter int          NUM_LANES    = 4,
  parameter int          POS_W        = 10,
  parameter int          SCREEN_WIDTH = 640,
  parameter int          SCORE_W      = 7,
  parameter int          CTR_W        = 18,
  parameter int          PERIOD       = 100000,
  parameter int          SPEED_SHIFT  = 9,
  parameter int          MIN_PERIOD   = 2000,
  parameter logic [31:0] LANE_STEPS   = {8{4'd2}},
  parameter int          LANE_OFFSET  = 160
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       restart,
  input  logic [SCORE_W-1:0]         score,
  input  logic [NUM_LANES-1:0]       lane_dir,
  output logic [NUM_LANES*POS_W-1:0] h_pos,
  output logic [NUM_LANES-1:0]       move_pulse,
  output logic                       tick
);

  typedef logic [NUM_LANES-1:0][POS_W-1:0] pos_t;

  localparam logic [CTR_W-1:0] PERIOD_M1  = CTR_W'(PERIOD - 1);
  localparam logic [CTR_W-1:0] MAX_RELOAD = CTR_W'(PERIOD - MIN_PERIOD);

  // Start-of-game layout: lanes are spread LANE_OFFSET pixels apart.
  function automatic pos_t init_pos();
    pos_t p;
    for (int i = 0; i < NUM_LANES; i++) begin
      p[i] = POS_W'((i * LANE_OFFSET) % SCREEN_WIDTH);
    end
    return p;
  endfunction

  // One modular step. The intermediate values are one bit wider than a
  // position, so p + s and p + SCREEN_WIDTH - s never overflow.
  function automatic logic [POS_W-1:0] lane_next(input logic [POS_W-1:0] p,
                                                 input logic [3:0]       s,
                                                 input logic             dir);
    logic [POS_W:0] pw, sw, mw, wide;
    pw = {1'b0, p};
    sw = (POS_W+1)'(s);
    mw = (POS_W+1)'(SCREEN_WIDTH);
    if (!dir) begin
      wide = pw + sw;
      if (wide >= mw) wide = wide - mw;
    end else begin
      if (pw < sw) wide = pw + mw - sw;
      else         wide = pw - sw;
    end
    return wide[POS_W-1:0];
  endfunction

  logic [CTR_W-1:0]     ctr_q, ctr_d;
  pos_t                 pos_q, pos_d;
  logic                 tick_q, tick_d;
  logic [NUM_LANES-1:0] move_q, move_d;

  logic [CTR_W-1:0] shifted;
  logic [CTR_W-1:0] reload;
  logic             tick_cycle;

  // The shift is done at counter width so that high score bits are kept.
  // The clamp then bounds the speed-up to MIN_PERIOD cycles per tick.
  assign shifted    = CTR_W'(score) << SPEED_SHIFT;
  assign reload     = (shifted > MAX_RELOAD) ? MAX_RELOAD : shifted;
  assign tick_cycle = enable && (ctr_q >= PERIOD_M1);

  // Next state for the prescaler, the lane positions and the pulse outputs.
  // The score and lane_dir inputs matter only on a tick cycle.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves one
    // unassigned; an unassigned path would infer a latch.
    ctr_d  = ctr_q;
    pos_d  = pos_q;
    tick_d = 1'b0;
    move_d = '0;
    if (restart) begin
      ctr_d = '0;
      pos_d = init_pos();
    end else if (enable) begin
      if (tick_cycle) begin
        ctr_d  = reload;
        tick_d = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
          if (LANE_STEPS[4*i +: 4] != 4'd0) begin
            pos_d[i]  = lane_next(pos_q[i], LANE_STEPS[4*i +: 4], lane_dir[i]);
            move_d[i] = 1'b1;
          end
        end
      end else begin
        ctr_d = ctr_q + 1'b1;
      end
    end
  end

  // State registers. The async reset matches the state left by restart.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // flop then samples the values from before the edge.
    if (!rst_n) begin
      ctr_q  <= '0;
      pos_q  <= init_pos();
      tick_q <= 1'b0;
      move_q <= '0;
    end else begin
      ctr_q  <= ctr_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
      move_q <= move_d;
    end
  end

  assign h_pos      = pos_q;
  assign move_pulse = move_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_scroll_lanes.sv
// Directed bench for scroll_lanes. It uses the small simulation parameters.
// A behavioural position model tracks the expected lane offsets. Outputs are
// sampled on the falling clock edge.
module tb_scroll_lanes;

  localparam int NL = 4;
  localparam int PW = 10;
  localparam int SW = 640;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             restart;
  logic [6:0]       score;
  logic [NL-1:0]    lane_dir;
  logic [NL*PW-1:0] h_pos;
  logic [NL-1:0]    move_pulse;
  logic             tick;

  int n_checks = 0;
  int n_errors = 0;

  // Lane steps: lane0=2, lane1=5, lane2=3, lane3=2.
  int steps[NL] = '{2, 5, 3, 2};
  int exp_pos[NL];

  scroll_lanes #(
    .NUM_LANES   (NL),
    .POS_W       (PW),
    .SCREEN_WIDTH(SW),
    .SCORE_W     (7),
    .CTR_W       (18),
    .PERIOD      (20),
    .SPEED_SHIFT (1),
    .MIN_PERIOD  (5),
    .LANE_STEPS  (32'h0000_2352),
    .LANE_OFFSET (160)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .restart   (restart),
    .score     (score),
    .lane_dir  (lane_dir),
    .h_pos     (h_pos),
    .move_pulse(move_pulse),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) exp_pos[i] = (i * 160) % SW;
  endtask

  task automatic model_tick();
    for (int i = 0; i < NL; i++) begin
      if (lane_dir[i]) exp_pos[i] = (exp_pos[i] - steps[i] + SW) % SW;
      else             exp_pos[i] = (exp_pos[i] + steps[i]) % SW;
    end
  endtask

  function automatic logic [NL*PW-1:0] model_vec();
    logic [NL*PW-1:0] v;
    for (int i = 0; i < NL; i++) v[PW*i +: PW] = PW'(exp_pos[i]);
    return v;
  endfunction

  // Waits, with a bound, for the next tick. It checks how many falling edges
  // that took, then checks the pulses and the positions against the model.
  task automatic run_to_tick(input int expected, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < expected + 40);
    check({tag, "_interval"}, 64'(n), 64'(expected));
    model_tick();
    check({tag, "_pulse"}, 64'(move_pulse), 64'(4'hF));
    check({tag, "_pos"}, 64'(h_pos), 64'(model_vec()));
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    restart  = 1'b0;
    score    = '0;
    lane_dir = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_pos", 64'(h_pos), 64'({10'd480, 10'd320, 10'd160, 10'd0}));
    check("reset_tick", 64'(tick), 64'(0));
    check("reset_pulse", 64'(move_pulse), 64'(0));
    rst_n = 1'b1;

    // Base period of 20 cycles
    run_to_tick(20, "first");
    check("lane1_165", 64'(h_pos[19:10]), 64'(165));
    run_to_tick(20, "second");

    // Lane 3 moves left from the next tick on
    lane_dir = 4'b1000;
    run_to_tick(20, "dir_change");

    // Speed-up: the in-flight interval stays at the old length
    score = 7'd5;
    run_to_tick(20, "s5_inflight");
    run_to_tick(10, "s5_a");
    run_to_tick(10, "s5_b");
    score = 7'd100;
    run_to_tick(10, "s100_inflight");
    // Clamped to 5 cycles. Enough ticks to make every lane wrap.
    for (int k = 0; k < 330; k++) run_to_tick(5, "fast");

    // Score drop applies from the following tick
    score = 7'd0;
    run_to_tick(5, "s0_inflight");
    run_to_tick(20, "s0_slow");

    // Freeze for 7 cycles in the middle of an interval
    repeat (8) @(negedge clk);
    enable = 1'b0;
    repeat (7) begin
      @(negedge clk);
      check("freeze_tick", 64'(tick), 64'(0));
      check("freeze_pulse", 64'(move_pulse), 64'(0));
    end
    check("freeze_pos", 64'(h_pos), 64'(model_vec()));
    enable = 1'b1;
    run_to_tick(12, "resume");

    // Restart on the tick cycle wins over the tick
    repeat (19) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    check("restart_tick", 64'(tick), 64'(0));
    check("restart_pulse", 64'(move_pulse), 64'(0));
    check("restart_pos", 64'(h_pos), 64'({10'd480, 10'd320, 10'd160, 10'd0}));
    restart = 1'b0;
    model_reset();
    run_to_tick(20, "after_restart");

    // Async reset in the middle of an interval clears before any clock edge
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_pos", 64'(h_pos), 64'({10'd480, 10'd320, 10'd160, 10'd0}));
    check("async_tick", 64'(tick), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_to_tick(20, "after_async");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
